// File: rtl/io_pkg.sv
// Shared io-bus definitions for the io_responder peripheral: register map and STAT layout.
package io_pkg;

    typedef logic [15:0] IoAddr;

    localparam IoAddr IO_TXD  = 16'h0000;
    localparam IoAddr IO_STAT = 16'h0001;
    localparam IoAddr IO_RXD  = 16'h0002;
    localparam IoAddr IO_TMR  = 16'h0003;

    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_RX_AVAIL = 2;
    localparam int unsigned STAT_OVF      = 3;
    localparam int unsigned STAT_UNF      = 4;
    localparam int unsigned STAT_CNT_LSB  = 8;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO without bypass; a push into a full FIFO is accepted only when a pop happens on the same edge.
module io_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             clk_en,
    input  logic             sync_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clk_en && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (sync_rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/io_responder.sv
// io-bus responder: console TX/RX FIFOs, STAT register with sticky ovf/unf flags, and a 16-bit cycle timer.
module io_responder
    import io_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        clk_en,
    input  logic        req,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [15:0] data,
    output logic [15:0] data_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready
);

    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    logic             tx_full, tx_empty, tx_pop, tx_push_req, ovf_set;
    logic [TX_CW-1:0] tx_count;
    logic             rx_full, rx_empty, rx_rd, rx_pop, rx_push, unf_set;
    logic [RX_CW-1:0] rx_count;
    logic [7:0]       rx_head;
    logic             stat_wr, tmr_wr;
    logic             ovf, unf;
    logic [15:0]      timer;
    logic [7:0]       tx_cnt_sat;
    logic [15:0]      stat_word;

    assign tx_push_req = req & write & (addr == IO_TXD);
    assign stat_wr     = req & write & (addr == IO_STAT);
    assign tmr_wr      = req & write & (addr == IO_TMR);
    assign rx_rd       = req & ~write & (addr == IO_RXD);

    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign ovf_set  = tx_push_req & tx_full & ~tx_pop;

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rx_rd & ~rx_empty;
    assign unf_set  = rx_rd & rx_empty;

    io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .clk_en   (clk_en),
        .sync_rst (sync_rst),
        .push     (tx_push_req),
        .pop      (tx_pop),
        .din      (data[7:0]),
        .dout     (tx_data),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    io_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .clk_en   (clk_en),
        .sync_rst (sync_rst),
        .push     (rx_push),
        .pop      (rx_pop),
        .din      (rx_data),
        .dout     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    // Sticky flags: a same-edge event beats a clear.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (sync_rst) begin
                ovf   <= 1'b0;
                unf   <= 1'b0;
                timer <= '0;
            end else begin
                if (ovf_set)                 ovf <= 1'b1;
                else if (stat_wr && data[3]) ovf <= 1'b0;
                if (unf_set)                 unf <= 1'b1;
                else if (stat_wr && data[4]) unf <= 1'b0;
                timer <= tmr_wr ? data : timer + 16'(1);
            end
        end
    end

    assign tx_cnt_sat = (32'(tx_count) > 32'd255) ? 8'hFF : 8'(tx_count);

    always_comb begin
        stat_word                  = '0;
        stat_word[STAT_TX_FULL]    = tx_full;
        stat_word[STAT_TX_EMPTY]   = tx_empty;
        stat_word[STAT_RX_AVAIL]   = (rx_count != '0);
        stat_word[STAT_OVF]        = ovf;
        stat_word[STAT_UNF]        = unf;
        stat_word[STAT_CNT_LSB+:8] = tx_cnt_sat;
    end

    // Read mux is purely combinational from addr and current state.
    always_comb begin
        data_out = '0;
        case (addr)
            IO_STAT: data_out = stat_word;
            IO_RXD:  data_out = rx_empty ? 16'h0000 : {8'h00, rx_head};
            IO_TMR:  data_out = timer;
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder: reset, TX/RX FIFOs, sticky flags, timer and clock enable.
module tb_io_responder;

    logic        clk = 1'b0;
    logic        sync_rst, clk_en, req, write;
    logic [15:0] addr, io_data, data_out;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]  tx_data, rx_data;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    io_responder #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk      (clk),
        .sync_rst (sync_rst),
        .clk_en   (clk_en),
        .req      (req),
        .write    (write),
        .addr     (addr),
        .data     (io_data),
        .data_out (data_out),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        req = 1'b1; write = 1'b1; addr = a; io_data = d;
        tick();
        req = 1'b0; write = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        req = 1'b1; write = 1'b0; addr = a;
        #1;
        d = data_out;
        tick();
        req = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        req = 1'b0; addr = a;
        #1;
        d = data_out;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        sync_rst = 1'b1;
        tick();
        sync_rst = 1'b0;
        repeat (5) tick();
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0002) begin tests_failed++; $display("FAIL reset_stat got %h exp 0002", v); end
        peek(16'h0003, v);
        tests_run++;
        if (v !== 16'h0005) begin tests_failed++; $display("FAIL reset_tmr got %h exp 0005", v); end
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        tests_run++;
        if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
        peek(16'h0004, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("FAIL unmapped_read got %h exp 0000", v); end
        peek(16'h0000, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("FAIL txd_read got %h exp 0000", v); end
    endtask

    task automatic test_tx_basic();
        logic [15:0] v;
        logic [7:0]  exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        tx_ready = 1'b0;
        cpu_write(16'h0000, 16'h0041);
        cpu_write(16'h0000, 16'h0042);
        cpu_write(16'h0000, 16'h0043);
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0300) begin tests_failed++; $display("FAIL tx_three_stat got %h exp 0300", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                tests_failed++;
                $display("FAIL tx_drain_%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, exp_b[i]);
            end
            tick();
        end
        tx_ready = 1'b0;
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0002 || tx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL tx_drained got stat=%h v=%b exp 0002 v=0", v, tx_valid);
        end
    endtask

    task automatic test_tx_overflow();
        logic [15:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) cpu_write(16'h0000, 16'(i));
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h1009) begin tests_failed++; $display("FAIL tx_ovf_stat got %h exp 1009", v); end
        tests_run++;
        if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL tx_ovf_head got %h exp 00", tx_data); end
        cpu_write(16'h0001, 16'h0008);
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h1001) begin tests_failed++; $display("FAIL ovf_clear got %h exp 1001", v); end
    endtask

    task automatic test_full_same_edge();
        logic [15:0] v;
        tx_ready = 1'b1;
        cpu_write(16'h0000, 16'h0099);
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h1001) begin tests_failed++; $display("FAIL full_push_pop_stat got %h exp 1001", v); end
        for (int i = 1; i < 16; i++) begin
            #1;
            tests_run++;
            if (tx_data !== 8'(i)) begin tests_failed++; $display("FAIL full_drain_%0d got %h exp %h", i, tx_data, 8'(i)); end
            tick();
        end
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h99) begin
            tests_failed++; $display("FAIL full_drain_16th got v=%b d=%h exp v=1 d=99", tx_valid, tx_data);
        end
        tick();
        tx_ready = 1'b0;
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drain_empty got %b exp 0", tx_valid); end
    endtask

    task automatic test_rx();
        logic [15:0] v;
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0006) begin tests_failed++; $display("FAIL rx_avail_stat got %h exp 0006", v); end
        cpu_read(16'h0002, v);
        tests_run++;
        if (v !== 16'h005A) begin tests_failed++; $display("FAIL rxd_read got %h exp 005a", v); end
        cpu_read(16'h0002, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("FAIL rxd_empty_read got %h exp 0000", v); end
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0012) begin tests_failed++; $display("FAIL unf_stat got %h exp 0012", v); end
        cpu_write(16'h0001, 16'h0010);
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0002) begin tests_failed++; $display("FAIL unf_clear got %h exp 0002", v); end
    endtask

    task automatic test_rx_full();
        logic [15:0] v;
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'hA0 + i);
            tick();
        end
        rx_data = 8'hEE;
        #1;
        tests_run++;
        if (rx_ready !== 1'b0) begin tests_failed++; $display("FAIL rx_full_ready got %b exp 0", rx_ready); end
        // Host keeps offering 0xEE; the pop frees a slot but the offer on that edge is refused.
        cpu_read(16'h0002, v);
        tests_run++;
        if (v !== 16'h00A0) begin tests_failed++; $display("FAIL rx_full_head got %h exp 00a0", v); end
        rx_valid = 1'b0;
        tests_run++;
        if (rx_ready !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_after_pop got %b exp 1", rx_ready); end
        for (int i = 1; i < 16; i++) cpu_read(16'h0002, v);
        tests_run++;
        if (v !== 16'h00AF) begin tests_failed++; $display("FAIL rx_last_byte got %h exp 00af", v); end
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0002) begin tests_failed++; $display("FAIL rx_drained_stat got %h exp 0002", v); end
    endtask

    task automatic test_timer_and_reset();
        logic [15:0] v;
        cpu_write(16'h0003, 16'hFFFE);
        peek(16'h0003, v);
        tests_run++;
        if (v !== 16'hFFFE) begin tests_failed++; $display("FAIL tmr_load got %h exp fffe", v); end
        tick();
        clk_en = 1'b0;
        req = 1'b1; write = 1'b1; addr = 16'h0000; io_data = 16'h0077;
        tick();
        req = 1'b0; write = 1'b0;
        clk_en = 1'b1;
        tick();
        peek(16'h0003, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("FAIL tmr_wrap got %h exp 0000", v); end
        tests_run++;
        if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL clk_en_low_write got tx_valid=%b exp 0", tx_valid); end
        tx_ready = 1'b0;
        cpu_write(16'h0000, 16'h0011);
        sync_rst = 1'b1;
        cpu_write(16'h0000, 16'h0022);
        sync_rst = 1'b0;
        peek(16'h0001, v);
        tests_run++;
        if (v !== 16'h0002 || tx_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_with_write got stat=%h v=%b exp 0002 v=0", v, tx_valid);
        end
        peek(16'h0003, v);
        tests_run++;
        if (v !== 16'h0000) begin tests_failed++; $display("FAIL rst_timer got %h exp 0000", v); end
    endtask

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1; req = 1'b0; write = 1'b0;
        addr = '0; io_data = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        test_reset();
        test_tx_basic();
        test_tx_overflow();
        test_full_same_edge();
        test_rx();
        test_rx_full();
        test_timer_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
